fp_mul_issue: RTL and testbench

FP_MUL_ISSUE -- requirements
Module: fp_mul_issue

---
 rtl/fp_mul_issue_pkg.sv | 20 ++
 rtl/fp_mul_issue_classify.sv | 46 ++++
 rtl/fp_mul_issue.sv | 175 +++++++++++++++++
 tb/tb_fp_mul_issue.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_mul_issue_pkg.sv
// rtl/fp_mul_issue_pkg.sv - shared types and constants for the FP multiply issue block
//
// Purpose: FSM state encoding and IEEE-754 single-precision constants used by
//          fp_mul_issue and fp_special_classify.
// Ports:   none (package).
package fp_mul_issue_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LAUNCH    = 3'd1,
      ST_WAIT_LOW  = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_HOLD_OUT  = 3'd4
   } state_t;

   localparam logic [31:0] QNAN     = 32'h7FC0_0000;
   localparam logic [7:0]  EXP_ALL1 = 8'hFF;
   localparam logic [7:0]  EXP_ZERO = 8'h00;

endpackage

// File: rtl/fp_mul_issue_classify.sv
// rtl/fp_mul_issue_classify.sv - special-operand detector for single-precision multiply
//
// Purpose: decides whether a product can be produced without the multiplier
//          (NaN, infinity or zero operands) and forms that product word.
// Ports:   i_a, i_b   - IEEE-754 single operands
//          o_bypass   - 1 when the product is fully determined by special operands
//          o_word     - bypass product word (0 when o_bypass=0)
module fp_special_classify
   import fp_mul_issue_pkg::*;
(
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic        o_bypass,
   output logic [31:0] o_word
);

   logic w_a_nan, w_a_inf, w_a_zero;
   logic w_b_nan, w_b_inf, w_b_zero;
   logic w_sign;

   // Denormals have a zero exponent and are deliberately treated as zero.
   assign w_a_nan  = (i_a[30:23] == EXP_ALL1) && (i_a[22:0] != 23'h0);
   assign w_a_inf  = (i_a[30:23] == EXP_ALL1) && (i_a[22:0] == 23'h0);
   assign w_a_zero = (i_a[30:23] == EXP_ZERO);
   assign w_b_nan  = (i_b[30:23] == EXP_ALL1) && (i_b[22:0] != 23'h0);
   assign w_b_inf  = (i_b[30:23] == EXP_ALL1) && (i_b[22:0] == 23'h0);
   assign w_b_zero = (i_b[30:23] == EXP_ZERO);
   assign w_sign   = i_a[31] ^ i_b[31];

   always_comb begin
      o_bypass = 1'b0;
      o_word   = 32'h0;
      // Invalid products (NaN in, or inf*0) win over every other special case.
      if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
         o_bypass = 1'b1;
         o_word   = QNAN;
      end else if (w_a_inf || w_b_inf) begin
         o_bypass = 1'b1;
         o_word   = {w_sign, EXP_ALL1, 23'h0};
      end else if (w_a_zero || w_b_zero) begin
         o_bypass = 1'b1;
         o_word   = {w_sign, 31'h0};
      end
   end

endmodule

// File: rtl/fp_mul_issue.sv
// rtl/fp_mul_issue.sv - issue/retire wrapper around an external FP multiplier
//
// Purpose: accepts one operand pair at a time, bypasses special operands,
//          otherwise launches the external multiplier, waits for completion
//          with a bounded timeout, and holds the result until consumed.
// Ports:   clk, rst (async, active-high)
//          in_valid/in_ready/in_a/in_b           - operand handshake
//          out_valid/out_ready/out_result        - result handshake
//          out_special, out_timeout              - result origin flags
//          mul_start/mul_a/mul_b                 - multiplier launch
//          mul_done/mul_result                   - multiplier idle level and product
module fp_mul_issue
   import fp_mul_issue_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 63
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic        out_special,
   output logic        out_timeout,
   output logic        mul_start,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   input  logic        mul_done,
   input  logic [31:0] mul_result
);

   localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES);

   state_t            r_state;
   state_t            w_next_state;
   logic [CNT_W-1:0]  r_wait_cnt;
   logic [CNT_W-1:0]  w_cnt_inc;
   logic [31:0]       r_mul_a;
   logic [31:0]       r_mul_b;
   logic [31:0]       r_out_result;
   logic              r_out_special;
   logic              r_out_timeout;

   logic              w_bypass;
   logic [31:0]       w_bypass_word;
   logic              w_load_ops;
   logic              w_cap_bypass;
   logic              w_cap_done;
   logic              w_cap_timeout;
   logic              w_waiting;

   fp_special_classify u_classify (
      .i_a      (in_a),
      .i_b      (in_b),
      .o_bypass (w_bypass),
      .o_word   (w_bypass_word)
   );

   // Accepting only while the multiplier reports idle also blocks new work
   // after a timeout until the abandoned run has drained.
   assign in_ready    = (r_state == ST_IDLE) && mul_done;
   assign out_valid   = (r_state == ST_HOLD_OUT);
   assign mul_start   = (r_state == ST_LAUNCH);
   assign mul_a       = r_mul_a;
   assign mul_b       = r_mul_b;
   assign out_result  = r_out_result;
   assign out_special = r_out_special;
   assign out_timeout = r_out_timeout;

   assign w_waiting = (r_state == ST_WAIT_LOW) || (r_state == ST_WAIT_DONE);
   assign w_cnt_inc = r_wait_cnt + CNT_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state  = r_state;
      w_load_ops    = 1'b0;
      w_cap_bypass  = 1'b0;
      w_cap_done    = 1'b0;
      w_cap_timeout = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (in_valid && mul_done) begin
               w_load_ops = 1'b1;
               if (w_bypass) begin
                  w_cap_bypass = 1'b1;
                  w_next_state = ST_HOLD_OUT;
               end else begin
                  w_next_state = ST_LAUNCH;
               end
            end
         end
         ST_LAUNCH: begin
            w_next_state = ST_WAIT_LOW;
         end
         ST_WAIT_LOW: begin
            // mul_done is still the pre-launch idle level until the
            // multiplier acknowledges the start by dropping it.
            if (w_cnt_inc == CNT_LAST) begin
               w_cap_timeout = 1'b1;
               w_next_state  = ST_HOLD_OUT;
            end else if (!mul_done) begin
               w_next_state = ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            // Completion is checked first so it wins on the timeout cycle.
            if (mul_done) begin
               w_cap_done   = 1'b1;
               w_next_state = ST_HOLD_OUT;
            end else if (w_cnt_inc == CNT_LAST) begin
               w_cap_timeout = 1'b1;
               w_next_state  = ST_HOLD_OUT;
            end
         end
         ST_HOLD_OUT: begin
            if (out_ready) begin
               w_next_state = ST_IDLE;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wait_cnt <= '0;
      end else if (r_state == ST_LAUNCH) begin
         r_wait_cnt <= '0;
      end else if (w_waiting) begin
         r_wait_cnt <= w_cnt_inc;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mul_a       <= 32'h0;
         r_mul_b       <= 32'h0;
         r_out_result  <= 32'h0;
         r_out_special <= 1'b0;
         r_out_timeout <= 1'b0;
      end else begin
         if (w_load_ops) begin
            r_mul_a <= in_a;
            r_mul_b <= in_b;
         end
         if (w_cap_bypass) begin
            r_out_result  <= w_bypass_word;
            r_out_special <= 1'b1;
            r_out_timeout <= 1'b0;
         end else if (w_cap_done) begin
            r_out_result  <= mul_result;
            r_out_special <= 1'b0;
            r_out_timeout <= 1'b0;
         end else if (w_cap_timeout) begin
            r_out_result  <= QNAN;
            r_out_special <= 1'b0;
            r_out_timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fp_mul_issue.sv
// tb/tb_fp_mul_issue.sv - self-checking bench for fp_mul_issue
module tb_fp_mul_issue;

   localparam int TMO = 63;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_a = 32'h0;
   logic [31:0] in_b = 32'h0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_result;
   logic        out_special;
   logic        out_timeout;
   logic        mul_start;
   logic [31:0] mul_a;
   logic [31:0] mul_b;
   logic        mul_done;
   logic [31:0] mul_result;

   int n_tests = 0;
   int n_fail  = 0;

   int   start_cnt;
   int   stub_lat  = 0;
   logic stub_hang = 1'b0;
   int   stub_cnt;
   logic stub_busy;

   always #5 clk = ~clk;

   fp_mul_issue #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_special(out_special), .out_timeout(out_timeout),
      .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
      .mul_done(mul_done), .mul_result(mul_result)
   );

   // Single-precision <-> real conversion for normal numbers via double bits.
   function automatic real sp2r(input logic [31:0] x);
      logic [10:0] e;
      e = {3'b000, x[30:23]} + 11'd896;
      return $bitstoreal({x[31], e, x[22:0], 29'd0});
   endfunction

   function automatic logic [31:0] r2sp(input real r);
      logic [63:0] d;
      logic [10:0] e;
      d = $realtobits(r);
      e = d[62:52] - 11'd896;
      return {d[63], e[7:0], d[51:29]};
   endfunction

   function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      return r2sp(sp2r(a) * sp2r(b));
   endfunction

   // 0 normal, 1 zero (incl. denormal), 2 infinity, 3 NaN
   function automatic int fp_class(input logic [31:0] x);
      if (x[30:23] == 8'hFF) return (x[22:0] == 0) ? 2 : 3;
      if (x[30:23] == 8'h00) return 1;
      return 0;
   endfunction

   function automatic logic [32:0] model_expect(input logic [31:0] a, input logic [31:0] b);
      int  ca, cb;
      logic s;
      ca = fp_class(a);
      cb = fp_class(b);
      s  = a[31] ^ b[31];
      if (ca == 3 || cb == 3 || (ca == 2 && cb == 1) || (ca == 1 && cb == 2))
         return {1'b1, 32'h7FC00000};
      if (ca == 2 || cb == 2) return {1'b1, s, 8'hFF, 23'h0};
      if (ca == 1 || cb == 1) return {1'b1, s, 31'h0};
      return {1'b0, ref_mul(a, b)};
   endfunction

   function automatic logic [31:0] gen_operand(input int cat);
      logic [31:0] x;
      logic        s;
      s = 1'($urandom_range(0, 1));
      case (cat)
         1:       x = {s, 8'h00, 23'($urandom_range(0, 32'h7FFFFF))};
         2:       x = {s, 8'hFF, 23'h0};
         3:       x = {s, 8'hFF, 23'($urandom_range(1, 32'h7FFFFF))};
         default: begin
            x = r2sp(real'($urandom_range(1, 4095)));
            x[31] = s;
         end
      endcase
      return x;
   endfunction

   // Multiplier stand-in: drops mul_done after a start, raises it again
   // stub_lat cycles later (or never while stub_hang=1) with the product.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         stub_busy  <= 1'b0;
         stub_cnt   <= 0;
         mul_done   <= 1'b1;
         mul_result <= 32'h0;
      end else if (!stub_busy) begin
         if (mul_start) begin
            stub_busy  <= 1'b1;
            mul_done   <= 1'b0;
            stub_cnt   <= stub_lat;
            mul_result <= 32'hDEADBEEF;
         end
      end else if (stub_cnt > 0) begin
         stub_cnt <= stub_cnt - 1;
      end else if (!stub_hang) begin
         stub_busy  <= 1'b0;
         mul_done   <= 1'b1;
         mul_result <= ref_mul(mul_a, mul_b);
      end
   end

   always @(posedge clk) begin
      if (mul_start) start_cnt <= start_cnt + 1;
   end

   task automatic wait_ready();
      int guard = 0;
      while (!in_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) begin
         n_tests++;
         n_fail++;
         $display("FAIL wait_in_ready: in_ready=%b required 1 within 200 cycles", in_ready);
      end
   endtask

   // Offers one pair, returns the number of negedges from the accept edge
   // until out_valid is seen; leaves the result held in HOLD_OUT.
   task automatic issue_op(input logic [31:0] a, input logic [31:0] b, output int lat);
      wait_ready();
      in_a     = a;
      in_b     = b;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 300) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_tests++;
      if ({out_valid, out_special, out_timeout, mul_start} !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_flags: valid/special/timeout/start=%b required 0000",
                  {out_valid, out_special, out_timeout, mul_start});
      end
      n_tests++;
      if (out_result !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_result: got %h required 00000000", out_result);
      end
      n_tests++;
      if ({mul_a, mul_b} !== 64'h0) begin
         n_fail++;
         $display("FAIL reset_operands: mul_a=%h mul_b=%h required 0", mul_a, mul_b);
      end
      rst = 1'b0;
      @(negedge clk);
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_in_ready: got %b required 1", in_ready);
      end
   endtask

   task automatic test_normal();
      int lat;
      int s0;
      stub_lat = 2;
      s0 = start_cnt;
      issue_op(32'h40400000, 32'h40000000, lat);
      n_tests++;
      if (out_result !== 32'h40C00000 || out_special !== 1'b0 || out_timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL normal_result: got %h sp=%b to=%b required 40c00000 sp=0 to=0",
                  out_result, out_special, out_timeout);
      end
      n_tests++;
      if (start_cnt - s0 !== 1) begin
         n_fail++;
         $display("FAIL normal_start_pulses: got %0d required 1", start_cnt - s0);
      end
      n_tests++;
      if (lat !== 6) begin
         n_fail++;
         $display("FAIL normal_latency: got %0d required 6", lat);
      end
      n_tests++;
      if (mul_a !== 32'h40400000 || mul_b !== 32'h40000000) begin
         n_fail++;
         $display("FAIL normal_operands: mul_a=%h mul_b=%h required 40400000 40000000", mul_a, mul_b);
      end
      release_out();
   endtask

   task automatic test_bypass();
      logic [31:0] ta [5];
      logic [31:0] tb [5];
      logic [31:0] tr [5];
      int lat;
      int s0;
      ta = '{32'h00000000, 32'h7F800000, 32'h7F800000, 32'h7FC12345, 32'h00000001};
      tb = '{32'hC0000000, 32'h00000000, 32'hC0000000, 32'h3F800000, 32'h3F800000};
      tr = '{32'h80000000, 32'h7FC00000, 32'hFF800000, 32'h7FC00000, 32'h00000000};
      for (int i = 0; i < 5; i++) begin
         s0 = start_cnt;
         issue_op(ta[i], tb[i], lat);
         n_tests++;
         if (out_result !== tr[i] || out_special !== 1'b1 || out_timeout !== 1'b0 || lat !== 1) begin
            n_fail++;
            $display("FAIL bypass_%0d: got %h sp=%b to=%b lat=%0d required %h sp=1 to=0 lat=1",
                     i, out_result, out_special, out_timeout, lat, tr[i]);
         end
         release_out();
         n_tests++;
         if (start_cnt - s0 !== 0) begin
            n_fail++;
            $display("FAIL bypass_start_%0d: got %0d pulses required 0", i, start_cnt - s0);
         end
      end
   endtask

   task automatic test_timeout();
      int lat;
      int bad;
      stub_lat  = 0;
      stub_hang = 1'b1;
      issue_op(32'h3FC00000, 32'h40800000, lat);
      n_tests++;
      if (out_result !== 32'h7FC00000 || out_timeout !== 1'b1 || out_special !== 1'b0 || lat !== TMO + 2) begin
         n_fail++;
         $display("FAIL timeout_result: got %h to=%b sp=%b lat=%0d required 7fc00000 to=1 sp=0 lat=%0d",
                  out_result, out_timeout, out_special, lat, TMO + 2);
      end
      release_out();
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         if (in_ready !== 1'b0) bad++;
         @(negedge clk);
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL timeout_blocks_accept: in_ready high %0d cycles required 0", bad);
      end
      stub_hang = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_recover: in_ready=%b required 1", in_ready);
      end
   endtask

   task automatic test_timeout_edge();
      int lat;
      stub_lat = TMO - 2;
      issue_op(32'h40A00000, 32'h40400000, lat);
      n_tests++;
      if (out_result !== 32'h41700000 || out_timeout !== 1'b0 || lat !== TMO + 2) begin
         n_fail++;
         $display("FAIL edge_completion_wins: got %h to=%b lat=%0d required 41700000 to=0 lat=%0d",
                  out_result, out_timeout, lat, TMO + 2);
      end
      release_out();
      stub_lat = TMO - 1;
      issue_op(32'h40A00000, 32'h40400000, lat);
      n_tests++;
      if (out_result !== 32'h7FC00000 || out_timeout !== 1'b1 || lat !== TMO + 2) begin
         n_fail++;
         $display("FAIL edge_one_late: got %h to=%b lat=%0d required 7fc00000 to=1 lat=%0d",
                  out_result, out_timeout, lat, TMO + 2);
      end
      release_out();
   endtask

   task automatic test_hold();
      int lat;
      int bad;
      logic [31:0] held;
      stub_lat = 1;
      issue_op(32'hC1200000, 32'h3F000000, lat);
      held = out_result;
      in_a = 32'h3F800000;
      in_b = 32'h3F800000;
      in_valid = 1'b1;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b1 || out_result !== held || in_ready !== 1'b0) bad++;
      end
      in_valid = 1'b0;
      n_tests++;
      if (bad != 0 || held !== 32'hC0A00000) begin
         n_fail++;
         $display("FAIL hold_stable: %0d unstable cycles, result %h required 0 and c0a00000", bad, held);
      end
      n_tests++;
      if (mul_a !== 32'hC1200000) begin
         n_fail++;
         $display("FAIL hold_no_accept: mul_a=%h required c1200000", mul_a);
      end
      release_out();
      issue_op(32'h3F800000, 32'h40E00000, lat);
      n_tests++;
      if (out_result !== 32'h40E00000 || out_special !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_resume: got %h sp=%b required 40e00000 sp=0", out_result, out_special);
      end
      release_out();
   endtask

   task automatic test_reset_mid();
      int lat;
      int seen;
      int s0;
      stub_lat = 30;
      wait_ready();
      in_a = 32'h40000000;
      in_b = 32'h40000000;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      n_tests++;
      if ({out_valid, out_special, out_timeout, mul_start} !== 4'b0 || out_result !== 32'h0 ||
          {mul_a, mul_b} !== 64'h0) begin
         n_fail++;
         $display("FAIL midreset_outputs: v/sp/to/st=%b res=%h a=%h b=%h required all 0",
                  {out_valid, out_special, out_timeout, mul_start}, out_result, mul_a, mul_b);
      end
      @(negedge clk);
      rst = 1'b0;
      s0 = start_cnt;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      n_tests++;
      if (seen != 0 || start_cnt != s0) begin
         n_fail++;
         $display("FAIL midreset_discard: out_valid %0d cycles, %0d starts required 0 and 0",
                  seen, start_cnt - s0);
      end
      stub_lat = 3;
      issue_op(32'h40400000, 32'h40000000, lat);
      n_tests++;
      if (out_result !== 32'h40C00000 || out_special !== 1'b0 || lat !== 7) begin
         n_fail++;
         $display("FAIL midreset_next_op: got %h sp=%b lat=%0d required 40c00000 sp=0 lat=7",
                  out_result, out_special, lat);
      end
      release_out();
   endtask

   task automatic test_random();
      logic [31:0] a, b;
      logic [32:0] exp_v;
      int lat, s0, ca, cb, ls;
      for (int n = 0; n < 40; n++) begin
         ca = $urandom_range(0, 7);
         cb = $urandom_range(0, 7);
         a  = gen_operand(ca < 4 ? 0 : ca - 4);
         b  = gen_operand(cb < 4 ? 0 : cb - 4);
         ls = $urandom_range(0, 5);
         stub_lat = ls;
         exp_v = model_expect(a, b);
         s0 = start_cnt;
         issue_op(a, b, lat);
         n_tests++;
         if (out_result !== exp_v[31:0] || out_special !== exp_v[32] || out_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL random_%0d: a=%h b=%h got %h sp=%b to=%b required %h sp=%b to=0",
                     n, a, b, out_result, out_special, out_timeout, exp_v[31:0], exp_v[32]);
         end
         n_tests++;
         if (start_cnt - s0 !== (exp_v[32] ? 0 : 1) || lat !== (exp_v[32] ? 1 : 4 + ls)) begin
            n_fail++;
            $display("FAIL random_timing_%0d: starts=%0d lat=%0d required %0d and %0d",
                     n, start_cnt - s0, lat, exp_v[32] ? 0 : 1, exp_v[32] ? 1 : 4 + ls);
         end
         repeat ($urandom_range(0, 2)) @(negedge clk);
         release_out();
      end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_bypass();
      test_timeout();
      test_timeout_edge();
      test_hold();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
